// File: rtl/vending_pkg.sv
// Shared vending definitions: change coin codes, coin values in nickel units,
// and the change dispenser state encoding.
package vending_pkg;

    typedef enum logic [2:0] {
        CC_NONE        = 3'b000,
        CC_NICKEL      = 3'b001,
        CC_DIME        = 3'b010,
        CC_NICKEL_DIME = 3'b011,
        CC_DIMES_2     = 3'b100,
        CC_QUARTER     = 3'b101
    } coin_code_e;

    localparam logic [2:0] NICKEL_UNITS = 3'd1;
    localparam logic [2:0] DIME_UNITS   = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_REQ    = 2'd2,
        ST_GAP    = 2'd3
    } disp_state_e;

    // Codes the dispenser can pay out; the quarter is not stocked.
    function automatic logic code_legal(input logic [2:0] code);
        logic ok;
        case (code)
            CC_NICKEL, CC_DIME, CC_NICKEL_DIME, CC_DIMES_2: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] code_units(input logic [2:0] code);
        logic [2:0] units;
        case (code)
            CC_NICKEL:      units = 3'd1;
            CC_DIME:        units = 3'd2;
            CC_NICKEL_DIME: units = 3'd3;
            CC_DIMES_2:     units = 3'd4;
            default:        units = 3'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/change_timer.sv
// Shared down-counter for the hopper ack timeout and the inter-coin gap.
module change_timer #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority; counting stops at zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= {W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != {W{1'b0}})) begin
            r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/change_dispenser.sv
// Pays a change code out one coin at a time over a hopper request/ack handshake.
// Optional coin inventory tracking is enabled by defining CHANGE_INVENTORY_EN.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 4,
    parameter int NICKEL_INIT = 8,
    parameter int DIME_INIT   = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             change_valid,
    input  logic [2:0]       change_code,
    output logic             change_ready,
    output logic             nickel_out,
    output logic             dime_out,
    input  logic             hopper_ack,
    output logic             busy,
    output logic             done,
    output logic             error,
    input  logic             refill,
    output logic [CNT_W-1:0] nickel_cnt,
    output logic [CNT_W-1:0] dime_cnt
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + GAP_CYCLES + 1);
    localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    disp_state_e r_state, w_state_nx;
    logic [2:0]  r_rem, w_rem_nx;
    logic        r_nickel_out, w_nickel_nx;
    logic        r_dime_out, w_dime_nx;
    logic        r_done, w_done_nx;
    logic        r_error, w_error_nx;
    logic        r_busy, r_change_ready;
    logic              w_tmr_load, w_tmr_en, w_tmr_zero;
    logic [TMR_W-1:0]  w_tmr_val;
    logic        w_take_n, w_take_d;
    logic        w_nickel_avail, w_dime_avail;

    change_timer #(.W(TMR_W)) u_timer (
        .i_clk      (Clk),
        .i_rst_n    (Reset_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    // Next-state, coin selection and handshake decisions.
    always_comb begin
        w_state_nx  = r_state;
        w_rem_nx    = r_rem;
        w_nickel_nx = r_nickel_out;
        w_dime_nx   = r_dime_out;
        w_done_nx   = 1'b0;
        w_error_nx  = r_error;
        w_tmr_load  = 1'b0;
        w_tmr_val   = {TMR_W{1'b0}};
        w_tmr_en    = 1'b0;
        w_take_n    = 1'b0;
        w_take_d    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nickel_nx = 1'b0;
                w_dime_nx   = 1'b0;
                if (change_valid && r_change_ready && (change_code != 3'b000)) begin
                    if (code_legal(change_code)) begin
                        w_rem_nx   = code_units(change_code);
                        w_error_nx = 1'b0;
                        w_state_nx = ST_SELECT;
                    end else begin
                        w_error_nx = 1'b1;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SELECT: begin
                // A dime is only chosen when it cannot overpay.
                if ((r_rem >= DIME_UNITS) && w_dime_avail) begin
                    w_dime_nx  = 1'b1;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = ACK_LOAD;
                    w_state_nx = ST_REQ;
                end else if (w_nickel_avail) begin
                    w_nickel_nx = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = ACK_LOAD;
                    w_state_nx  = ST_REQ;
                end else begin
                    w_error_nx = 1'b1;
                    w_rem_nx   = 3'd0;
                    w_state_nx = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (hopper_ack) begin
                    if (r_dime_out) begin
                        w_rem_nx = r_rem - DIME_UNITS;
                        w_take_d = 1'b1;
                    end else begin
                        w_rem_nx = r_rem - NICKEL_UNITS;
                        w_take_n = 1'b1;
                    end
                    w_nickel_nx = 1'b0;
                    w_dime_nx   = 1'b0;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = GAP_LOAD;
                    w_state_nx  = ST_GAP;
                end else if (w_tmr_zero) begin
                    w_nickel_nx = 1'b0;
                    w_dime_nx   = 1'b0;
                    w_error_nx  = 1'b1;
                    w_rem_nx    = 3'd0;
                    w_state_nx  = ST_IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_tmr_zero) begin
                    if (r_rem != 3'd0) begin
                        w_state_nx = ST_SELECT;
                    end else begin
                        w_done_nx  = 1'b1;
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_rem_nx    = 3'd0;
                w_nickel_nx = 1'b0;
                w_dime_nx   = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state        <= ST_IDLE;
            r_rem          <= 3'd0;
            r_nickel_out   <= 1'b0;
            r_dime_out     <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_busy         <= 1'b0;
            r_change_ready <= 1'b1;
        end else begin
            r_state        <= w_state_nx;
            r_rem          <= w_rem_nx;
            r_nickel_out   <= w_nickel_nx;
            r_dime_out     <= w_dime_nx;
            r_done         <= w_done_nx;
            r_error        <= w_error_nx;
            r_busy         <= (w_state_nx != ST_IDLE);
            r_change_ready <= (w_state_nx == ST_IDLE);
        end
    end

`ifdef CHANGE_INVENTORY_EN
    logic [CNT_W-1:0] r_nickel_cnt, r_dime_cnt;

    // Inventory: reload on refill while idle, decrement per acked coin.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_nickel_cnt <= CNT_W'(NICKEL_INIT);
            r_dime_cnt   <= CNT_W'(DIME_INIT);
        end else if (refill && (r_state == ST_IDLE)) begin
            r_nickel_cnt <= CNT_W'(NICKEL_INIT);
            r_dime_cnt   <= CNT_W'(DIME_INIT);
        end else begin
            r_nickel_cnt <= r_nickel_cnt - {{(CNT_W-1){1'b0}}, w_take_n};
            r_dime_cnt   <= r_dime_cnt - {{(CNT_W-1){1'b0}}, w_take_d};
        end
    end

    assign w_nickel_avail = (r_nickel_cnt != {CNT_W{1'b0}});
    assign w_dime_avail   = (r_dime_cnt != {CNT_W{1'b0}});
    assign nickel_cnt     = r_nickel_cnt;
    assign dime_cnt       = r_dime_cnt;
`else
    logic w_unused;

    assign w_nickel_avail = 1'b1;
    assign w_dime_avail   = 1'b1;
    assign nickel_cnt     = {CNT_W{1'b0}};
    assign dime_cnt       = {CNT_W{1'b0}};
    assign w_unused       = ^{refill, w_take_n, w_take_d, CNT_W'(NICKEL_INIT), CNT_W'(DIME_INIT)};
`endif

    assign change_ready = r_change_ready;
    assign nickel_out   = r_nickel_out;
    assign dime_out     = r_dime_out;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected coin/done/error
// events, an independent monitor pops and compares them as the DUT produces them.
module tb_change_dispenser;

    localparam int EV_NICKEL = 1;
    localparam int EV_DIME   = 2;
    localparam int EV_DONE   = 3;
    localparam int EV_ERR    = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       change_valid = 1'b0;
    logic [2:0] change_code = 3'b000;
    logic       hopper_ack = 1'b0;
    logic       refill = 1'b0;
    logic       change_ready, nickel_out, dime_out, busy, done, error;
    logic [3:0] nickel_cnt, dime_cnt;

    int exp_q[$];
    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    change_dispenser dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .change_valid (change_valid),
        .change_code  (change_code),
        .change_ready (change_ready),
        .nickel_out   (nickel_out),
        .dime_out     (dime_out),
        .hopper_ack   (hopper_ack),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .refill       (refill),
        .nickel_cnt   (nickel_cnt),
        .dime_cnt     (dime_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mon_event(input int got);
        int e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got %0d expected none", got);
        end else begin
            e = exp_q.pop_front();
            check("event_order", got, e);
        end
    endtask

    // Monitor: coin request rising edges, done pulses, error rising edges.
    logic p_n = 1'b0, p_d = 1'b0, p_e = 1'b0;
    always @(negedge Clk) begin
        if (nickel_out && !p_n) mon_event(EV_NICKEL);
        if (dime_out && !p_d)   mon_event(EV_DIME);
        if (done)               mon_event(EV_DONE);
        if (error && !p_e)      mon_event(EV_ERR);
        p_n <= nickel_out;
        p_d <= dime_out;
        p_e <= error;
    end

    // Issue one request and act as the hopper until the dispenser is idle again.
    task automatic run_txn(input logic [2:0] code, input bit ack_en,
                           output int coins, output int dones, output int last_hi,
                           output int min_gap, output int first_hi, output bit timed_out);
        int  hi_len, gap;
        bit  prev_coin, coin, fin;
        coins = 0; dones = 0; last_hi = 0; min_gap = 999; first_hi = 0;
        timed_out = 1'b0; hi_len = 0; gap = 0; prev_coin = 1'b0; fin = 1'b0;
        @(negedge Clk);
        change_valid = 1'b1;
        change_code  = code;
        @(negedge Clk);
        change_valid = 1'b0;
        change_code  = 3'b000;
        for (int step = 1; step <= 200 && !fin; step++) begin
            if (step > 1) @(negedge Clk);
            coin = nickel_out | dime_out;
            if (coin && !prev_coin) begin
                coins++;
                if (first_hi == 0) first_hi = step;
                if (coins > 1 && gap < min_gap) min_gap = gap;
                gap = 0;
            end
            if (coin) hi_len++;
            else if (prev_coin) begin
                last_hi = hi_len;
                hi_len  = 0;
            end else gap++;
            if (done) dones++;
            if (hopper_ack) hopper_ack = 1'b0;
            else if (coin && ack_en && hi_len == 1) hopper_ack = 1'b1;
            prev_coin = coin;
            if (!busy) fin = 1'b1;
        end
        hopper_ack = 1'b0;
        if (!fin) begin
            timed_out = 1'b1;
            check("txn_bound", 0, 1);
        end
    endtask

    int  c, d, lh, mg, fh;
    bit  to;

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_ready", change_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_nickel", nickel_out, 0);
        check("rst_dime", dime_out, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
`ifdef CHANGE_INVENTORY_EN
        check("rst_ncnt", nickel_cnt, 8);
        check("rst_dcnt", dime_cnt, 8);
`else
        check("rst_ncnt", nickel_cnt, 0);
        check("rst_dcnt", dime_cnt, 0);
`endif
        Reset_n = 1'b1;

`ifdef CHANGE_INVENTORY_EN
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(EV_DIME); exp_q.push_back(EV_DIME); exp_q.push_back(EV_DONE);
            run_txn(3'b100, 1'b1, c, d, lh, mg, fh, to);
        end
        check("inv_dcnt_empty", dime_cnt, 0);
        check("inv_ncnt_full", nickel_cnt, 8);
        exp_q.push_back(EV_NICKEL); exp_q.push_back(EV_NICKEL); exp_q.push_back(EV_DONE);
        run_txn(3'b010, 1'b1, c, d, lh, mg, fh, to);
        check("inv_fallback_coins", c, 2);
        check("inv_fallback_ncnt", nickel_cnt, 6);
        check("inv_fallback_done", d, 1);
        repeat (4) exp_q.push_back(EV_NICKEL);
        exp_q.push_back(EV_DONE);
        run_txn(3'b100, 1'b1, c, d, lh, mg, fh, to);
        exp_q.push_back(EV_NICKEL); exp_q.push_back(EV_NICKEL); exp_q.push_back(EV_DONE);
        run_txn(3'b010, 1'b1, c, d, lh, mg, fh, to);
        check("inv_ncnt_empty", nickel_cnt, 0);
        exp_q.push_back(EV_ERR);
        run_txn(3'b001, 1'b1, c, d, lh, mg, fh, to);
        check("inv_empty_coins", c, 0);
        check("inv_empty_done", d, 0);
        check("inv_empty_error", error, 1);
        @(negedge Clk); refill = 1'b1;
        @(negedge Clk); refill = 1'b0;
        check("refill_ncnt", nickel_cnt, 8);
        check("refill_dcnt", dime_cnt, 8);
`endif

        exp_q.push_back(EV_DIME); exp_q.push_back(EV_NICKEL); exp_q.push_back(EV_DONE);
        run_txn(3'b011, 1'b1, c, d, lh, mg, fh, to);
        check("c15_coins", c, 2);
        check("c15_done", d, 1);
        check("c15_error", error, 0);
        check("c15_latency", fh, 2);
        check("c15_hold", lh, 1);

        exp_q.push_back(EV_DIME); exp_q.push_back(EV_DIME); exp_q.push_back(EV_DONE);
        run_txn(3'b100, 1'b1, c, d, lh, mg, fh, to);
        check("c20_coins", c, 2);
        check("c20_done", d, 1);
        check("c20_gap_ge2", (mg >= 2) ? 1 : 0, 1);

        run_txn(3'b000, 1'b1, c, d, lh, mg, fh, to);
        check("c00_coins", c, 0);
        check("c00_busy", busy, 0);
        check("c00_error", error, 0);

        exp_q.push_back(EV_ERR);
        run_txn(3'b110, 1'b1, c, d, lh, mg, fh, to);
        check("ill_error", error, 1);
        check("ill_coins", c, 0);
        check("ill_ready", change_ready, 1);

        exp_q.push_back(EV_NICKEL); exp_q.push_back(EV_DONE);
        run_txn(3'b001, 1'b1, c, d, lh, mg, fh, to);
        check("c05_error_clr", error, 0);
        check("c05_coins", c, 1);
        check("c05_done", d, 1);

        exp_q.push_back(EV_NICKEL); exp_q.push_back(EV_ERR);
        run_txn(3'b001, 1'b0, c, d, lh, mg, fh, to);
        check("tmo_hold", lh, 16);
        check("tmo_error", error, 1);
        check("tmo_done", d, 0);
        check("tmo_busy", busy, 0);

        // Reset while a nickel request is pending.
        exp_q.push_back(EV_NICKEL);
        @(negedge Clk); change_valid = 1'b1; change_code = 3'b001;
        @(negedge Clk); change_valid = 1'b0; change_code = 3'b000;
        for (int i = 0; i < 10 && !nickel_out; i++) @(negedge Clk);
        check("mid_req_seen", nickel_out, 1);
        @(negedge Clk); Reset_n = 1'b0;
        @(negedge Clk);
        check("mid_rst_nickel", nickel_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", change_ready, 1);
        Reset_n = 1'b1;
        @(negedge Clk); hopper_ack = 1'b1;
        @(negedge Clk); hopper_ack = 1'b0;
        @(negedge Clk);
        check("late_ack_busy", busy, 0);
        check("late_ack_done", done, 0);

        repeat (5) @(negedge Clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Payout side of the vending machine's change interface.
- Accepts a 3-bit change code, the same coin encoding the vending FSM drives on its change output.
- Pays it out one coin at a time to a coin hopper through a request/ack handshake, preferring dimes over nickels.
- Sits between the vending FSM and the hopper driver; reports completion and faults.

Parameters:
- ACK_TIMEOUT, 16, max cycles in REQ waiting for hopper_ack before fault.
- GAP_CYCLES, 2, idle cycles between consecutive coin requests (hopper settle time).
- CNT_W, 4, width of inventory counters.
- NICKEL_INIT, 8, nickel inventory after reset (inventory feature only).
- DIME_INIT, 8, dime inventory after reset (inventory feature only).

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- change_valid  in  1  change request valid.
- change_code  in  3  001=5c, 010=10c, 011=15c, 100=20c; 000=no change; 101-111 illegal.
- change_ready  out  1  high only in IDLE.
- nickel_out  out  1  request hopper to eject one nickel; held until ack.
- dime_out  out  1  request hopper to eject one dime; held until ack.
- hopper_ack  in  1  hopper has ejected the requested coin.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a request is fully paid.
- error  out  1  sticky fault flag.
- refill  in  1  reload inventory to INIT values (inventory feature only; ignored otherwise).
- nickel_cnt  out  CNT_W  nickel inventory (0 without feature).
- dime_cnt  out  CNT_W  dime inventory (0 without feature).

Behaviour:
- Clk and Reset_n: one clock; reset is synchronous and active-low.
- Reset (Reset_n low at an edge):
  - state=IDLE; nickel_out, dime_out, done, error, busy = 0; change_ready=1.
  - remaining=0; counters load INIT values.
  - Reset mid-operation abandons the request; coin lines are low after that edge.
- All outputs are registered.
- Accept: an edge with change_valid && change_ready.
  - Code 000 is not accepted; nothing happens.
  - Code 101-111 is accepted: error=1, no coins, stay IDLE.
  - Legal code: remaining = amount in nickel units (1,2,3,4); error cleared; go to SELECT.
- SELECT (1 cycle):
  - remaining>=2 and a dime is available -> dime.
  - Otherwise, a nickel is available -> nickel.
  - Otherwise -> error=1, remaining=0, IDLE, no done.
  - Go to REQ with the selected coin line high.
- Latency: coin line goes high 2 edges after the accept edge.
- REQ:
  - Exactly one coin line high; a timeout counter runs.
  - hopper_ack sampled high: remaining -= 1 (nickel) or 2 (dime); coin line low at the same edge; go to GAP.
  - ACK_TIMEOUT cycles without ack: coin line low, error=1, remaining=0, IDLE, no done.
- GAP: GAP_CYCLES cycles, then:
  - remaining>0 -> SELECT.
  - remaining==0 -> IDLE, with done=1 for the first IDLE cycle.
- Other rules:
  - hopper_ack outside REQ is ignored.
  - change_valid while busy is ignored; not queued.
  - remaining never underflows: a dime is only chosen when remaining>=2.
  - error clears only on reset or on the next accepted legal request.
- Example: 15c pays dime then nickel; 20c pays two dimes.

Optional Feature:
- Macro: CHANGE_INVENTORY_EN.
- With the macro:
  - nickel_cnt and dime_cnt decrement on each acked coin of that type.
  - A coin type counts as available only while its count is nonzero; an empty dime store falls back to nickels.
  - refill (IDLE only) reloads both counters; refill while busy is ignored.
- Without the macro:
  - Both coins are always available.
  - Counters are tied to 0; refill is ignored.

Decomposition:
- Shared package vending_pkg holds:
  - coin codes (nickel, dime, nickel_dime, dimes_2, quarter);
  - coin values in nickel units;
  - dispenser state encoding (IDLE, SELECT, REQ, GAP).
- Natural sub-module: change_timer, a shared down-counter for the ACK_TIMEOUT and GAP_CYCLES countdowns (load/enable/zero outputs).

Test Plan:
- Code 011, hopper_ack 1 cycle after each request -> dime_out then nickel_out, one done pulse, error=0.
- Code 100 -> two dime_out handshakes separated by >=2 GAP cycles, done once.
- CHANGE_INVENTORY_EN, dime_cnt=0, code 010 -> two nickel handshakes, nickel_cnt 8->6.
- CHANGE_INVENTORY_EN, both counts 0, code 001 -> error=1, no coin line, no done.
- Code 001, hopper_ack never asserted -> nickel_out high 16 cycles then low, error=1, IDLE, no done.
- Code 110 -> error=1, no coins; then code 001 with ack -> error clears, one nickel, done.
- Reset_n low during REQ -> coin line low and IDLE after that edge; a later ack is ignored.
